rgen_host_arbiter: RTL and testbench



---
 rtl/rgen_host_arbiter.sv | 118 +++++++++++
 tb/tb_rgen_host_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgen_host_arbiter.sv
// Round-robin arbiter sharing one local register command bus between HOSTS host ports.
// Grant is held until the register block responds; the response is steered to the owner only.

module rgen_host_arbiter_lane #(
  parameter int IDX = 0,
  parameter int PW  = 1
) (
  input  logic          valid,
  input  logic [PW-1:0] ptr,
  input  logic          grant,
  input  logic          rsp,
  output logic          req_hi,
  output logic          rsp_out
);
  // Requests at or above the pointer win over wrapped-around ones.
  assign req_hi  = valid && (PW'(IDX) >= ptr);
  assign rsp_out = grant && rsp;
endmodule

module rgen_host_arbiter #(
  parameter int HOSTS               = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int LOCAL_ADDRESS_WIDTH = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [HOSTS-1:0]                                i_command_valid,
  input  logic [HOSTS-1:0]                                i_write,
  input  logic [HOSTS-1:0]                                i_read,
  input  logic [HOSTS-1:0][LOCAL_ADDRESS_WIDTH-1:0]       i_address,
  input  logic [HOSTS-1:0][DATA_WIDTH-1:0]                i_write_data,
  input  logic [HOSTS-1:0][DATA_WIDTH-1:0]                i_write_mask,
  output logic [HOSTS-1:0]                                o_response_ready,
  output logic [DATA_WIDTH-1:0]                           o_read_data,
  output logic [1:0]                                      o_status,
  output logic                                            o_command_valid,
  output logic                                            o_write,
  output logic                                            o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]                  o_address,
  output logic [DATA_WIDTH-1:0]                           o_write_data,
  output logic [DATA_WIDTH-1:0]                           o_write_mask,
  input  logic                                            i_response_ready,
  input  logic [DATA_WIDTH-1:0]                           i_read_data,
  input  logic [1:0]                                      i_status,
  output logic [HOSTS-1:0]                                o_grant
);
  localparam int PW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PW-1:0]   ptr, gidx, win_idx;
  logic [HOSTS-1:0] req_hi;

  for (genvar g = 0; g < HOSTS; g++) begin : g_lane
    rgen_host_arbiter_lane #(.IDX(g), .PW(PW)) u_lane (
      .valid   (i_command_valid[g]),
      .ptr     (ptr),
      .grant   (o_grant[g]),
      .rsp     (i_response_ready),
      .req_hi  (req_hi[g]),
      .rsp_out (o_response_ready[g])
    );
  end

  // Lowest-index request wins; the pointer-masked pass overrides the wrap-around pass.
  always_comb begin
    win_idx = '0;
    for (int i = HOSTS - 1; i >= 0; i--)
      if (i_command_valid[i]) win_idx = PW'(i);
    for (int i = HOSTS - 1; i >= 0; i--)
      if (req_hi[i]) win_idx = PW'(i);
  end

  assign o_read_data = i_read_data;
  assign o_status    = i_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      gidx            <= '0;
      o_grant         <= '0;
      o_command_valid <= 1'b0;
      o_write         <= 1'b0;
      o_read          <= 1'b0;
      o_address       <= '0;
      o_write_data    <= '0;
      o_write_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_command_valid) begin
            state           <= BUSY;
            gidx            <= win_idx;
            o_grant         <= HOSTS'(1) << win_idx;
            o_command_valid <= 1'b1;
            o_write         <= i_write[win_idx];
            o_read          <= i_read[win_idx];
            o_address       <= i_address[win_idx];
            o_write_data    <= i_write_data[win_idx];
            o_write_mask    <= i_write_mask[win_idx];
          end
        end
        BUSY: begin
          // Command fields stay frozen until the register block answers.
          if (i_response_ready) begin
            state           <= IDLE;
            o_grant         <= '0;
            o_command_valid <= 1'b0;
            ptr             <= (gidx == PW'(HOSTS - 1)) ? '0 : gidx + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgen_host_arbiter.sv
// Scoreboard bench for rgen_host_arbiter with three hosts: expected commands and
// responses are queued as stimulus is driven and compared when the DUT emits them.

module tb_rgen_host_arbiter;
  localparam int H  = 3;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [H-1:0]          i_command_valid, i_write, i_read;
  logic [H-1:0][AW-1:0]  i_address;
  logic [H-1:0][DW-1:0]  i_write_data, i_write_mask;
  logic [H-1:0]          o_response_ready, o_grant;
  logic [DW-1:0]         o_read_data, o_write_data, o_write_mask, i_read_data;
  logic [1:0]            o_status, i_status;
  logic                  o_command_valid, o_write, o_read, i_response_ready;
  logic [AW-1:0]         o_address;

  rgen_host_arbiter #(.HOSTS(H), .DATA_WIDTH(DW), .LOCAL_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_command_valid(i_command_valid), .i_write(i_write), .i_read(i_read),
    .i_address(i_address), .i_write_data(i_write_data), .i_write_mask(i_write_mask),
    .o_response_ready(o_response_ready), .o_read_data(o_read_data), .o_status(o_status),
    .o_command_valid(o_command_valid), .o_write(o_write), .o_read(o_read),
    .o_address(o_address), .o_write_data(o_write_data), .o_write_mask(o_write_mask),
    .i_response_ready(i_response_ready), .i_read_data(i_read_data), .i_status(i_status),
    .o_grant(o_grant)
  );

  typedef struct {
    int            host;
    logic          wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, mk;
  } cmd_t;

  typedef struct {
    logic [H-1:0]  vec;
    logic [DW-1:0] rdata;
    logic [1:0]    st;
  } rsp_t;

  cmd_t cq[$];
  rsp_t rq[$];
  cmd_t cap;
  int   n_checks = 0, n_err = 0;
  int   rsp_cnt[H];
  logic prev_cv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: compares each new command and each response pulse against the queues.
  always @(negedge clk) begin
    if (!rst_n) prev_cv = 1'b0;
    else begin
      if (o_command_valid && !prev_cv) begin
        if (cq.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          cap = cq.pop_front();
          chk("cmd_grant", o_grant, H'(1) << cap.host);
          chk("cmd_write", o_write, cap.wr);
          chk("cmd_read", o_read, cap.rd);
          chk("cmd_addr", o_address, cap.addr);
          chk("cmd_wdata", o_write_data, cap.wd);
          chk("cmd_mask", o_write_mask, cap.mk);
        end
      end else if (o_command_valid) begin
        chk("frozen_grant", o_grant, H'(1) << cap.host);
        chk("frozen_addr", o_address, cap.addr);
        chk("frozen_wdata", o_write_data, cap.wd);
      end
      if (|o_response_ready) begin
        rsp_t r;
        for (int i = 0; i < H; i++) if (o_response_ready[i]) rsp_cnt[i]++;
        if (rq.size() == 0) chk("rsp_stray", o_response_ready, 0);
        else begin
          r = rq.pop_front();
          chk("rsp_vec", o_response_ready, r.vec);
          chk("rsp_data", o_read_data, r.rdata);
          chk("rsp_status", o_status, r.st);
        end
      end
      prev_cv = o_command_valid;
    end
  end

  task automatic clear_inputs();
    i_command_valid = '0; i_write = '0; i_read = '0; i_address = '0;
    i_write_data = '0; i_write_mask = '0; i_response_ready = 1'b0;
    i_read_data = '0; i_status = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_host(input int h, input logic wr, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    i_write[h] = wr; i_read[h] = rd; i_address[h] = a;
    i_write_data[h] = d; i_write_mask[h] = m; i_command_valid[h] = 1'b1;
  endtask

  task automatic push_cmd(input int h);
    cmd_t c;
    c.host = h; c.wr = i_write[h]; c.rd = i_read[h]; c.addr = i_address[h];
    c.wd = i_write_data[h]; c.mk = i_write_mask[h];
    cq.push_back(c);
  endtask

  // Counts negedges until o_command_valid is seen high, bounded.
  task automatic wait_cmd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_command_valid && n < 20);
    if (!o_command_valid) chk("cmd_timeout", 0, 1);
  endtask

  // Register-block model: answers lat cycles later with one response pulse.
  task automatic respond(input int h, input int lat, input logic [DW-1:0] rd, input logic [1:0] st);
    rsp_t r;
    repeat (lat) @(posedge clk);
    #1;
    r.vec = H'(1) << h; r.rdata = rd; r.st = st;
    rq.push_back(r);
    i_response_ready = 1'b1; i_read_data = rd; i_status = st;
    @(posedge clk); #1;
    i_response_ready = 1'b0;
    i_command_valid[h] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    clear_inputs();
    for (int i = 0; i < H; i++) rsp_cnt[i] = 0;

    // Reset state, including a response strobe held during reset.
    i_response_ready = 1'b1;
    #2;
    chk("rst_cv", o_command_valid, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_rsp", o_response_ready, 0);
    chk("rst_wr_rd", {o_write, o_read}, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_wd_mk", {o_write_data, o_write_mask}, 0);
    i_response_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write from host 0, two-cycle local latency.
    set_host(0, 1'b1, 1'b0, 8'h04, 32'hA5A5_0000, 32'hFFFF_0000);
    push_cmd(0);
    wait_cmd(n);
    chk("arb_latency", n, 2);
    respond(0, 2, 32'h0, 2'b00);
    repeat (2) @(posedge clk);

    // Simultaneous requests from reset: host 0 first, host 1 after the bubble.
    do_reset();
    set_host(0, 1'b1, 1'b0, 8'h10, 32'h1111_1111, 32'hFFFF_FFFF);
    set_host(1, 1'b0, 1'b1, 8'h14, 32'h2222_2222, 32'h0000_FFFF);
    push_cmd(0); push_cmd(1);
    wait_cmd(n);
    respond(0, 1, 32'hAAAA_0000, 2'b00);
    wait_cmd(n);
    chk("bubble", n, 2);
    respond(1, 1, 32'hBBBB_0001, 2'b00);
    repeat (2) @(posedge clk);

    // Fairness: all three hosts requesting continuously for nine transactions.
    do_reset();
    for (int i = 0; i < H; i++) rsp_cnt[i] = 0;
    for (int h = 0; h < H; h++)
      set_host(h, 1'b1, 1'b0, AW'(8'h20 + h * 4), $urandom, $urandom);
    for (int i = 0; i < 9; i++) push_cmd(i % H);
    for (int i = 0; i < 9; i++) begin
      wait_cmd(n);
      respond(i % H, 1, $urandom, 2'b00);
      if (i < 6) begin
        @(posedge clk); #1;
        i_command_valid[i % H] = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    for (int h = 0; h < H; h++) chk($sformatf("fair_cnt%0d", h), rsp_cnt[h], 3);

    // Host 1 read queued behind host 0; error status routed only to host 1.
    do_reset();
    set_host(0, 1'b1, 1'b0, 8'h20, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    push_cmd(0);
    wait_cmd(n);
    @(posedge clk); #1;
    set_host(1, 1'b0, 1'b1, 8'h08, 32'h0, 32'h0);
    push_cmd(1);
    respond(0, 2, 32'h0BAD_0BAD, 2'b00);
    wait_cmd(n);
    respond(1, 1, 32'h1234_5678, 2'b10);
    repeat (2) @(posedge clk);

    // Granted host changes address and drops valid mid-transaction (ptr now 2).
    set_host(0, 1'b1, 1'b0, 8'h30, 32'h3030_3030, 32'h00FF_00FF);
    push_cmd(0);
    wait_cmd(n);
    @(posedge clk); #1;
    i_address[0] = 8'hFF;
    i_command_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_cv", o_command_valid, 1);
    chk("hold_addr", o_address, 8'h30);
    respond(0, 1, 32'h0, 2'b00);
    repeat (2) @(posedge clk);

    // Stray response in IDLE is ignored.
    #1;
    i_response_ready = 1'b1;
    @(negedge clk);
    chk("stray_rsp", o_response_ready, 0);
    @(posedge clk); #1;
    i_response_ready = 1'b0;
    @(negedge clk);
    chk("stray_idle", o_command_valid, 0);

    // Reset mid-BUSY: outputs clear at once, ptr restarts at 0 (ptr was 1 here).
    @(posedge clk); #1;
    set_host(2, 1'b1, 1'b0, 8'h40, 32'h4040_4040, 32'hFFFF_FFFF);
    push_cmd(2);
    wait_cmd(n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rstb_cv", o_command_valid, 0);
    chk("rstb_grant", o_grant, 0);
    chk("rstb_addr", o_address, 0);
    chk("rstb_wd", o_write_data, 0);
    chk("rstb_wr", o_write, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_host(0, 1'b1, 1'b0, 8'h50, 32'h5050_5050, 32'hFFFF_FFFF);
    set_host(2, 1'b0, 1'b1, 8'h60, 32'h0, 32'h0);
    push_cmd(0); push_cmd(2);
    wait_cmd(n);
    respond(0, 1, 32'h0, 2'b00);
    wait_cmd(n);
    respond(2, 2, 32'h6666_6666, 2'b00);
    repeat (3) @(posedge clk);

    chk("cmd_queue_empty", cq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
